// File: rtl/pipo_load_arbiter.sv
// Arbiter and load sequencer for one shared PIPO register: grant, single load, fixed hold.
// Define PIPO_ARB_FIXED_PRIO_EN to replace round-robin selection with fixed lowest-index priority.
module pipo_load_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    din,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [WIDTH-1:0]         o,
  output logic                     o_vld,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  o_q, o_d;
  logic              o_vld_q, o_vld_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rearm_q, rearm_d;

  logic              found;
  logic [IW-1:0]     win;

`ifdef PIPO_ARB_FIXED_PRIO_EN
  always_comb begin
    found = |req;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
  end
`else
  always_comb begin
    int            idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx  = (int'(ptr_q) + i) % NREQ;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end
`endif

  // rearm_q blocks the first IDLE cycle after a hold so grants are HOLD+3 apart.
  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    o_d     = o_q;
    o_vld_d = 1'b0;
    cnt_d   = cnt_q;
    rearm_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found && !rearm_q) begin
          gnt_d   = NREQ'(1) << win;
          owner_d = win;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        o_d     = din[int'(owner_q)*WIDTH +: WIDTH];
        o_vld_d = 1'b1;
        cnt_d   = CW'(HOLD - 1);
`ifndef PIPO_ARB_FIXED_PRIO_EN
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
`endif
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          rearm_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      o_q     <= '0;
      o_vld_q <= 1'b0;
      cnt_q   <= '0;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      o_q     <= o_d;
      o_vld_q <= o_vld_d;
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign o         = o_q;
  assign o_vld     = o_vld_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Bench for pipo_load_arbiter: vector table, hand sequences and random traffic against a timeline model.
module tb_pipo_load_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] din;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [3:0]  o;
  logic        o_vld;
  logic        busy;
  logic [1:0]  dbg_state;

  pipo_load_arbiter #(.NREQ(4), .WIDTH(4), .HOLD(2)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .owner(owner),
    .o(o), .o_vld(o_vld), .busy(busy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec;
  int unsigned n_err;

  // Timeline model: a request sampled in cycle ls yields gnt in ls+1, new o and o_vld in ls+2,
  // busy over ls+1..ls+3, and the next sample may be taken no earlier than ls+5.
  int          t;
  int          ls;
  logic [1:0]  m_w;
  logic [1:0]  m_ptr;
  logic [1:0]  m_owner;
  logic [3:0]  m_o;
  logic [3:0]  m_o_pend;

  task automatic model_reset();
    ls      = -100;
    m_w     = 2'd0;
    m_ptr   = 2'd0;
    m_owner = 2'd0;
    m_o     = 4'd0;
  endtask

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] res;
    res = 2'd0;
`ifdef PIPO_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) if (r[i]) res = 2'(i);
`else
    for (int i = 3; i >= 0; i--) if (r[(int'(p) + i) % 4]) res = 2'((int'(p) + i) % 4);
`endif
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got %0h want %0h", nm, t, act, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] eg;
    eg = (t == ls + 1) ? (4'b0001 << m_w) : 4'b0000;
    chk("gnt",   32'(gnt),   32'(eg));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("o",     32'(o),     32'(m_o));
    chk("o_vld", 32'(o_vld), 32'(t == ls + 2));
    chk("busy",  32'(busy),  32'((t >= ls + 1) && (t <= ls + 3)));
  endtask

  task automatic step(input logic [3:0] r, input logic [15:0] d);
    req = r;
    din = d;
    if (t == ls + 1) m_o_pend = d[int'(m_w)*4 +: 4];
    if (r != 4'd0 && t >= ls + 5) begin
      ls  = t;
      m_w = pick(r, m_ptr);
`ifndef PIPO_ARB_FIXED_PRIO_EN
      m_ptr = m_w + 2'd1;
`endif
    end
    @(posedge clk);
    #1;
    t++;
    if (t == ls + 1) m_owner = m_w;
    if (t == ls + 2) m_o = m_o_pend;
    check_all();
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [3:0]  o;
    logic        vld;
    logic        busy;
  } vec_t;

  vec_t tbl[14];
  int   gcyc[$];
  logic [1:0] gown[$];

  initial begin
    logic [1:0] exp_own[4];
    n_vec = 0;
    n_err = 0;
    t     = 0;
    m_o_pend = 4'd0;
    model_reset();

    // single load, late request during hold, wrap to requester 0
    tbl[0]  = '{4'b0100, 16'h0A00, 4'b0100, 2'd2, 4'h0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0000, 16'h0A00, 4'b0000, 2'd2, 4'hA, 1'b1, 1'b1};
    tbl[2]  = '{4'b0000, 16'h0000, 4'b0000, 2'd2, 4'hA, 1'b0, 1'b1};
    tbl[3]  = '{4'b0000, 16'h0000, 4'b0000, 2'd2, 4'hA, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 16'h0000, 4'b0000, 2'd2, 4'hA, 1'b0, 1'b0};
    tbl[5]  = '{4'b1000, 16'h5000, 4'b1000, 2'd3, 4'hA, 1'b0, 1'b1};
    tbl[6]  = '{4'b0000, 16'h5000, 4'b0000, 2'd3, 4'h5, 1'b1, 1'b1};
    tbl[7]  = '{4'b0010, 16'h0000, 4'b0000, 2'd3, 4'h5, 1'b0, 1'b1};
    tbl[8]  = '{4'b0010, 16'h0000, 4'b0000, 2'd3, 4'h5, 1'b0, 1'b0};
    tbl[9]  = '{4'b0000, 16'h0000, 4'b0000, 2'd3, 4'h5, 1'b0, 1'b0};
    tbl[10] = '{4'b1001, 16'h9008, 4'b0001, 2'd0, 4'h5, 1'b0, 1'b1};
    tbl[11] = '{4'b0000, 16'h9008, 4'b0000, 2'd0, 4'h8, 1'b1, 1'b1};
    tbl[12] = '{4'b0000, 16'h0000, 4'b0000, 2'd0, 4'h8, 1'b0, 1'b1};
    tbl[13] = '{4'b0000, 16'h0000, 4'b0000, 2'd0, 4'h8, 1'b0, 1'b0};

    // reset held with random inputs, then released with req=0
    rst = 1'b0;
    req = 4'd0;
    din = 16'd0;
    for (int i = 0; i < 4; i++) begin
      req = 4'($urandom_range(0, 15));
      din = 16'($urandom);
      @(posedge clk);
      #1;
      check_all();
    end
    rst = 1'b1;
    req = 4'd0;
    step(4'd0, 16'd0);
    step(4'd0, 16'd0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].req, tbl[i].din);
      chk($sformatf("tbl%0d_gnt", i),   32'(gnt),   32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
      chk($sformatf("tbl%0d_o", i),     32'(o),     32'(tbl[i].o));
      chk($sformatf("tbl%0d_vld", i),   32'(o_vld), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
    end

    // all requesters held: order 1,2,3,0 (ptr is 1 after the wrap load), 5 cycles apart
    for (int i = 0; i < 20; i++) begin
      step(4'hF, 16'h4321);
      if (gnt != 4'd0) begin
        gcyc.push_back(t);
        gown.push_back(owner);
      end
    end
`ifdef PIPO_ARB_FIXED_PRIO_EN
    exp_own = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_own = '{2'd1, 2'd2, 2'd3, 2'd0};
`endif
    chk("fair_ngrants", 32'(gcyc.size()), 32'd4);
    for (int k = 0; k < gcyc.size() && k < 4; k++) begin
      chk($sformatf("fair_owner%0d", k), 32'(gown[k]), 32'(exp_own[k]));
      if (k > 0) chk($sformatf("fair_gap%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd5);
    end

    // reset asserted in the LOAD cycle of a load of 5 by requester 3
    for (int i = 0; i < 6; i++) step(4'd0, 16'd0);
    step(4'b0100, 16'h0000);
    for (int i = 0; i < 4; i++) step(4'd0, 16'd0);
    step(4'b1000, 16'h5000);
    chk("rst_pre_gnt", 32'(gnt), 32'h8);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_async_gnt", 32'(gnt),   32'd0);
    chk("rst_async_o",   32'(o),     32'd0);
    chk("rst_async_vld", 32'(o_vld), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;
    step(4'b1001, 16'h9008);
    chk("rst_ptr_gnt", 32'(gnt), 32'h1);
    step(4'd0, 16'h9008);
    chk("rst_ptr_o", 32'(o), 32'h8);
    for (int i = 0; i < 4; i++) step(4'd0, 16'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) step(4'd0, 16'($urandom));
      else step(4'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Round-robin arbiter and load sequencer that shares one WIDTH-bit parallel-in/parallel-out register among NREQ requesters. Each grant admits exactly one parallel load, then holds the register contents stable for a fixed number of cycles before the next arbitration. The block sits in front of the PIPO register datapath. It owns the register's load timing, so requesters never drive the register directly.

## Interface
- NREQ, 4: number of requesters; minimum 2.
- WIDTH, 4: register width in bits.
- HOLD, 2: cycles the register is held after a load before re-arbitration; minimum 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. rst=0 clears all state immediately.
- req  in  NREQ  per-requester load request, level-sensitive.
- din  in  NREQ*WIDTH  packed load data; requester k drives din[k*WIDTH +: WIDTH].
- gnt  out  NREQ  registered one-hot grant, high for exactly one cycle per load.
- owner  out  $clog2(NREQ)  index of the last granted requester.
- o  out  WIDTH  register contents.
- o_vld  out  1  one-cycle pulse in the first cycle new data is on o.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values:
  - state=IDLE, ptr=0.
  - gnt=0, owner=0, o=0, o_vld=0, busy=0, hold count=0.
- FSM states:
  - **IDLE:** if any req bit is set, select winner w. At the clock edge: gnt<=one-hot(w), owner<=w, state<=LOAD. If req==0, stay in IDLE with outputs unchanged (o_vld=0).
  - **LOAD:** lasts exactly one cycle. At the edge: o<=din slice w, o_vld<=1, gnt<=0, cnt<=HOLD-1, ptr<=(w+1) mod NREQ, state<=HOLD.
  - **HOLD:** o_vld<=0 after its first cycle and o is frozen. If cnt==0, state<=IDLE; otherwise cnt<=cnt-1.
- Winner selection (round-robin): the first set req bit searching upward from ptr, wrapping from NREQ-1 to 0.
- Load rules:
  - The requester must present valid data on its din slice during the cycle gnt is high; that is the only sample point.
  - The load completes even if req drops in the LOAD cycle. Deasserting req does not cancel a granted load.
- Request rules:
  - Requests arriving during LOAD or HOLD are not granted until the FSM returns to IDLE. Nothing is queued; req is re-sampled in IDLE.
  - A requester that keeps req high after its load competes again. Because of the round-robin pointer, it is served last among the active requesters.
- busy = (state != IDLE), decoded combinationally from the state register.

## Timing
- req sampled at cycle 0 (IDLE) -> gnt high in cycle 1 -> o updated and o_vld high in cycle 2.
- State occupancy: HOLD covers cycles 2..HOLD+1; IDLE resumes at cycle HOLD+2.
- Minimum spacing between consecutive grants: HOLD+3 cycles. With HOLD=2, grants fall in cycles 1, 6, 11, ...
- Reset mid-operation: asserting rst in LOAD or HOLD clears gnt, o and o_vld asynchronously. No partial load occurs and ptr returns to 0.
- Boundary cases:
  - A single requester held continuously is re-granted every HOLD+3 cycles.
  - All requesters active: grant order is ptr, ptr+1, ... with wrap-around.

## Configuration
- PIPO_ARB_FIXED_PRIO_EN
  - **Defined:** fixed priority; the lowest-index set req bit always wins, and ptr is neither updated nor used.
  - **Undefined (default):** round-robin as specified above.
- All timing and handshake behaviour is identical in both modes.

## Test plan
- Reset: hold rst=0 with random req and din -> gnt=0, o=0, o_vld=0, busy=0, owner=0. Release rst with req=0 -> outputs stay at reset values.
- Single load: req=4'b0100, din slice2=4'hA at cycle 0 -> gnt=4'b0100 in cycle 1; o=4'hA, o_vld=1, owner=2 in cycle 2; busy high in cycles 1-3; IDLE in cycle 4.
- Round-robin fairness: req=4'b1111 held, slice k data = k+1 -> loads in order 1,2,3,0 with o = 2,3,4,1 and grants 5 cycles apart. Under PIPO_ARB_FIXED_PRIO_EN, every grant goes to requester 0.
- Wrap: after requester 3 is served, assert req=4'b1001 -> requester 0 is granted next, not 3.
- Late request: assert req[1] during HOLD only, deasserted before IDLE -> no grant and o unchanged.
- Reset mid-op: assert rst in the LOAD cycle of a load of 4'h5 -> o stays 0 and no o_vld pulse; after release, the next grant searches from index 0.
